// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and entry layout for the MIPS hazard scoreboard.
// Imported by the scoreboard top and its operand matcher.
package hazard_scoreboard_pkg;

    localparam logic [3:0] TUSE_NONE = 4'hf;
    localparam int DEF_CNT_W = 32;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam int ENT_W = 10;

    typedef struct packed {
        logic       valid;
        logic [4:0] tar;
        logic [3:0] tnew;
    } sb_entry_t;

    function automatic logic [3:0] sat_dec(input logic [3:0] x);
        return (x == 4'd0) ? 4'd0 : x - 4'd1;
    endfunction

    function automatic logic sb_match(input sb_entry_t x,
                                      input logic [4:0] r);
        return x.valid && (x.tar == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Nearest-writer lookup for one operand: stall request and forward select.
// Priority E > M > W; older matches are shadowed by the nearest one.
module hazard_match
    import hazard_scoreboard_pkg::*;
(
    input  logic [4:0]       reg_i,
    input  logic [3:0]       use_i,
    input  logic [ENT_W-1:0] ent_e_i,
    input  logic [ENT_W-1:0] ent_m_i,
    input  logic [ENT_W-1:0] ent_w_i,
    output logic             stall_req_o,
    output logic [1:0]       fwd_sel_o
);

    sb_entry_t  ent_e;
    sb_entry_t  ent_m;
    sb_entry_t  ent_w;
    logic       hit;
    logic [3:0] hit_tnew;
    logic [1:0] hit_sel;

    assign ent_e = sb_entry_t'(ent_e_i);
    assign ent_m = sb_entry_t'(ent_m_i);
    assign ent_w = sb_entry_t'(ent_w_i);

    always_comb begin
        hit      = 1'b0;
        hit_tnew = 4'd0;
        hit_sel  = FWD_RF;
        if (sb_match(ent_e, reg_i)) begin
            hit      = 1'b1;
            hit_tnew = ent_e.tnew;
            hit_sel  = FWD_E;
        end else if (sb_match(ent_m, reg_i)) begin
            hit      = 1'b1;
            hit_tnew = ent_m.tnew;
            hit_sel  = FWD_M;
        end else if (sb_match(ent_w, reg_i)) begin
            hit      = 1'b1;
            hit_tnew = ent_w.tnew;
            hit_sel  = FWD_W;
        end
    end

    assign stall_req_o = hit && (use_i != TUSE_NONE)
                         && (hit_tnew > use_i);
    assign fwd_sel_o = (hit && hit_tnew == 4'd0) ? hit_sel : FWD_RF;

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for the 5-stage MIPS pipeline with a
// stall-cycle counter; tracks writers in E, M and W.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [3:0]       d_rs_use,
    input  logic [3:0]       d_rt_use,
    input  logic [4:0]       d_tar,
    input  logic [3:0]       d_tnew,
    output logic             stall,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e,
    output logic [CNT_W-1:0] stall_cnt
);

    sb_entry_t        e_q, e_d;
    sb_entry_t        m_q, m_d;
    sb_entry_t        w_q, w_d;
    logic [4:0]       e_rs_q, e_rs_d;
    logic [4:0]       e_rt_q, e_rt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic      stall_rs;
    logic      stall_rt;
    logic      unused_stall_rs_e;
    logic      unused_stall_rt_e;
    sb_entry_t e_masked;

    // E-stage operands can only forward from M or W
    assign e_masked = '{valid: 1'b0, tar: e_q.tar, tnew: e_q.tnew};

    hazard_match u_rs_d (
        .reg_i       (d_rs),
        .use_i       (d_rs_use),
        .ent_e_i     (e_q),
        .ent_m_i     (m_q),
        .ent_w_i     (w_q),
        .stall_req_o (stall_rs),
        .fwd_sel_o   (fwd_rs_d)
    );

    hazard_match u_rt_d (
        .reg_i       (d_rt),
        .use_i       (d_rt_use),
        .ent_e_i     (e_q),
        .ent_m_i     (m_q),
        .ent_w_i     (w_q),
        .stall_req_o (stall_rt),
        .fwd_sel_o   (fwd_rt_d)
    );

    hazard_match u_rs_e (
        .reg_i       (e_rs_q),
        .use_i       (TUSE_NONE),
        .ent_e_i     (e_masked),
        .ent_m_i     (m_q),
        .ent_w_i     (w_q),
        .stall_req_o (unused_stall_rs_e),
        .fwd_sel_o   (fwd_rs_e)
    );

    hazard_match u_rt_e (
        .reg_i       (e_rt_q),
        .use_i       (TUSE_NONE),
        .ent_e_i     (e_masked),
        .ent_m_i     (m_q),
        .ent_w_i     (w_q),
        .stall_req_o (unused_stall_rt_e),
        .fwd_sel_o   (fwd_rt_e)
    );

    assign stall = (stall_rs | stall_rt) & d_valid;

    always_comb begin
        m_d      = e_q;
        m_d.tnew = sat_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = sat_dec(m_q.tnew);
        e_d      = '0;
        e_rs_d   = 5'd0;
        e_rt_d   = 5'd0;
        if (!stall) begin
            e_d.valid = d_valid;
            e_d.tar   = d_tar;
            e_d.tnew  = sat_dec(d_tnew);
            e_rs_d    = d_rs;
            e_rt_d    = d_rt;
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            e_rs_q <= 5'd0;
            e_rt_q <= 5'd0;
            cnt_q  <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            e_rs_q <= e_rs_d;
            e_rt_q <= e_rt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline sequences from a table,
// then random traffic against a pipeline-age reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_rs, d_rt, d_tar;
    logic [3:0]  d_rs_use, d_rt_use, d_tnew;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [31:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rs_use  (d_rs_use),
        .d_rt_use  (d_rt_use),
        .d_tar     (d_tar),
        .d_tnew    (d_tnew),
        .stall     (stall),
        .fwd_rs_d  (fwd_rs_d),
        .fwd_rt_d  (fwd_rt_d),
        .fwd_rs_e  (fwd_rs_e),
        .fwd_rt_e  (fwd_rt_e),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [3:0] rsu;
        logic [4:0] rt;
        logic [3:0] rtu;
        logic [4:0] tar;
        logic [3:0] tnew;
        logic       stl;
        logic [1:0] frsd, frtd, frse, frte;
        int         cnt;
    } vec_t;

    localparam logic [3:0] NU = 4'hf;

    vec_t tbl[24];

    function automatic vec_t mk(
        input logic rst,
        input int rs, input logic [3:0] rsu,
        input int rt, input logic [3:0] rtu,
        input int tar, input int tnew,
        input logic stl, input int a, input int b,
        input int c, input int d, input int cnt);
        vec_t v;
        v.rst = rst;
        v.rs = rs[4:0]; v.rsu = rsu;
        v.rt = rt[4:0]; v.rtu = rtu;
        v.tar = tar[4:0]; v.tnew = tnew[3:0];
        v.stl = stl;
        v.frsd = a[1:0]; v.frtd = b[1:0];
        v.frse = c[1:0]; v.frte = d[1:0];
        v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string nm, input logic es,
                         input int a, input int b,
                         input int c, input int d,
                         input int ec);
        n_vec++;
        if (stall !== es || fwd_rs_d !== a[1:0]
            || fwd_rt_d !== b[1:0] || fwd_rs_e !== c[1:0]
            || fwd_rt_e !== d[1:0] || stall_cnt !== ec) begin
            n_err++;
            $display("FAIL %s: got st=%0b fd=%0d/%0d fe=%0d/%0d cnt=%0d want st=%0b fd=%0d/%0d fe=%0d/%0d cnt=%0d",
                nm, stall, fwd_rs_d, fwd_rt_d, fwd_rs_e,
                fwd_rt_e, stall_cnt, es, a, b, c, d, ec);
        end
    endtask

    // Reference model: in-flight instructions indexed by how many
    // stages past D they are; remaining latency is tnew minus age.
    typedef struct {
        bit v;
        int tar, tnew, rs, rt, rsu, rtu;
    } ins_t;

    ins_t pipe[1:3];
    int   m_cnt;

    function automatic int rem(input ins_t x, input int k);
        return (x.tnew - k < 0) ? 0 : x.tnew - k;
    endfunction

    task automatic look(input int r, input int u, input int lo,
                        output bit st, output int fw,
                        output int rm, output bit hit);
        st = 0; fw = 0; rm = 0; hit = 0;
        for (int k = lo; k <= 3; k++) begin
            if (!hit && pipe[k].v && pipe[k].tar == r && r != 0) begin
                hit = 1;
                rm  = rem(pipe[k], k);
                st  = (u != 15) && (rm > u);
                fw  = (rm == 0) ? k : 0;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0, 0, 15, 15};
        m_cnt = 0;
    endtask

    task automatic apply(input logic rst, input logic v,
                         input int rs, input int rsu,
                         input int rt, input int rtu,
                         input int tar, input int tnew);
        reset = rst; d_valid = v;
        d_rs = rs[4:0]; d_rs_use = rsu[3:0];
        d_rt = rt[4:0]; d_rt_use = rtu[3:0];
        d_tar = tar[4:0]; d_tnew = tnew[3:0];
    endtask

    int uses[3] = '{0, 1, 15};

    initial begin
        tbl[0]  = mk(0, 1,1,  2,1,  3,2,  0,0,0,0,0,0);
        tbl[1]  = mk(0, 3,1,  0,1,  4,2,  0,0,0,0,0,0);
        tbl[2]  = mk(0, 0,NU, 0,NU, 0,0,  0,0,0,2,0,0);
        tbl[3]  = mk(0, 3,0,  0,0,  0,0,  0,3,0,0,0,0);
        tbl[4]  = mk(0, 1,1,  5,NU, 5,3,  0,0,0,0,0,0);
        tbl[5]  = mk(0, 0,1,  5,1,  6,2,  1,0,0,0,0,0);
        tbl[6]  = mk(0, 0,1,  5,1,  6,2,  0,0,0,0,0,1);
        tbl[7]  = mk(0, 0,NU, 0,NU, 0,0,  0,0,0,0,3,1);
        tbl[8]  = mk(0, 1,1,  5,NU, 5,3,  0,0,0,0,0,1);
        tbl[9]  = mk(0, 5,0,  0,0,  0,0,  1,0,0,0,0,1);
        tbl[10] = mk(0, 5,0,  0,0,  0,0,  1,0,0,0,0,2);
        tbl[11] = mk(0, 5,0,  0,0,  0,0,  0,3,0,0,0,3);
        tbl[12] = mk(0, 0,NU, 0,NU, 31,1, 0,0,0,0,0,3);
        tbl[13] = mk(0, 31,0, 0,NU, 0,0,  0,1,0,0,0,3);
        tbl[14] = mk(0, 0,1,  0,NU, 0,2,  0,0,0,2,0,3);
        tbl[15] = mk(0, 0,0,  0,0,  0,0,  0,0,0,0,0,3);
        tbl[16] = mk(0, 0,NU, 0,NU, 7,1,  0,0,0,0,0,3);
        tbl[17] = mk(0, 1,1,  2,1,  7,2,  0,0,0,0,0,3);
        tbl[18] = mk(0, 7,0,  0,0,  0,0,  1,0,0,0,0,3);
        tbl[19] = mk(0, 7,0,  0,0,  0,0,  0,2,0,0,0,4);
        tbl[20] = mk(0, 1,1,  5,NU, 5,3,  0,0,0,3,0,4);
        tbl[21] = mk(0, 5,0,  0,0,  0,0,  1,0,0,0,0,4);
        tbl[22] = mk(1, 5,0,  0,0,  0,0,  1,0,0,0,0,5);
        tbl[23] = mk(0, 5,0,  0,0,  0,0,  0,0,0,0,0,0);

        apply(1, 0, 0, 15, 0, 15, 0, 0);
        repeat (2) @(negedge clk);
        apply(0, 0, 0, 15, 0, 15, 0, 0);
        #2 check("reset_state", 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i].rst, 1, tbl[i].rs, tbl[i].rsu,
                  tbl[i].rt, tbl[i].rtu, tbl[i].tar, tbl[i].tnew);
            #2 check($sformatf("dir%0d", i), tbl[i].stl,
                     tbl[i].frsd, tbl[i].frtd,
                     tbl[i].frse, tbl[i].frte, tbl[i].cnt);
        end

        @(negedge clk);
        apply(1, 0, 0, 15, 0, 15, 0, 0);
        model_clear();

        for (int n = 0; n < 3000; n++) begin
            bit   st_a, st_b, st_c, st_d, h_a, h_b, h_c, h_d;
            int   fa, fb, fc, fd, ra, rb, rc, rd;
            bit   rs_st;
            logic r_rst, r_v;
            int   rs, rt, rsu, rtu, tar, tn;
            @(negedge clk);
            r_rst = ($urandom_range(0, 79) == 0);
            r_v   = ($urandom_range(0, 9) != 0);
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            rsu = uses[$urandom_range(0, 2)];
            rtu = uses[$urandom_range(0, 2)];
            tar = $urandom_range(0, 7);
            tn  = $urandom_range(0, 3);
            apply(r_rst, r_v, rs, rsu, rt, rtu, tar, tn);
            #2;
            look(rs, rsu, 1, st_a, fa, ra, h_a);
            look(rt, rtu, 1, st_b, fb, rb, h_b);
            look(pipe[1].rs, 15, 2, st_c, fc, rc, h_c);
            look(pipe[1].rt, 15, 2, st_d, fd, rd, h_d);
            rs_st = (st_a | st_b) & r_v;
            check($sformatf("rnd%0d", n), rs_st,
                  fa, fb, fc, fd, m_cnt);
            if (pipe[1].v && ((pipe[1].rsu != 15 && h_c && rc != 0)
                || (pipe[1].rtu != 15 && h_d && rd != 0))) begin
                n_err++;
                $display("FAIL tuse_guard%0d: got rem=%0d/%0d want 0",
                         n, rc, rd);
            end
            if (r_rst) begin
                model_clear();
            end else begin
                m_cnt += rs_st;
                pipe[3] = pipe[2];
                pipe[2] = pipe[1];
                if (rs_st)
                    pipe[1] = '{0, 0, 0, 0, 0, 15, 15};
                else if (r_v)
                    pipe[1] = '{1, tar, tn, rs, rt, rsu, rtu};
                else
                    pipe[1] = '{0, tar, tn, rs, rt, 15, 15};
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard controller for the 5-stage MIPS pipeline (F, D, E, M, W).
- Consumes the per-instruction Tuse/Tnew/target-register info produced by the fetch/decode logic for the instruction entering D.
- Tracks in-flight writers in E, M and W, decides stalls, and drives the forward-mux selects for the D and E operand paths.
- Also keeps a stall-cycle performance counter.

Parameters:
- TUSE_NONE, 4'hf, Tuse encoding meaning "operand not read"
- CNT_W, 32, width of stall performance counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- d_valid  input  1  D stage holds a real instruction (0 = bubble)
- d_rs  input  5  rs field of D instruction
- d_rt  input  5  rt field of D instruction
- d_rs_use  input  4  Tuse of rs: 0 = read in D, 1 = read in E, TUSE_NONE = unused
- d_rt_use  input  4  Tuse of rt, same encoding
- d_tar  input  5  destination register of D instruction (0 = none)
- d_tnew  input  4  Tnew of D instruction, counted from D (alu 2, lw 3, jal 1, others 0)
- stall  output  1  freeze PC and F/D register; insert bubble into E
- fwd_rs_d  output  2  D-stage rs source: 0 RF, 1 E, 2 M, 3 W
- fwd_rt_d  output  2  D-stage rt source, same encoding
- fwd_rs_e  output  2  E-stage rs source: 0 ID/EX value, 2 M, 3 W
- fwd_rt_e  output  2  E-stage rt source, same encoding
- stall_cnt  output  CNT_W  number of cycles in which stall was 1

Behaviour:
- State: three entries E, M, W, each holding {valid, tar[4:0], tnew[3:0]}. E additionally holds rs[4:0] and rt[4:0] of the E instruction.
- Reset (synchronous): all entries invalid, tar = 0, tnew = 0, E.rs/E.rt = 0, stall_cnt = 0. Outputs are then stall = 0 and all fwd = 0.
- Advance on every clock edge (the pipeline never freezes downstream of D):
  - W <= M with tnew = sat_dec(M.tnew).
  - M <= E with tnew = sat_dec(E.tnew).
  - If stall = 0: E <= {d_valid, d_tar, sat_dec(d_tnew), d_rs, d_rt}.
  - If stall = 1: E <= bubble (valid = 0, tar = 0, tnew = 0, rs = rt = 0).
- sat_dec(x) = (x == 0) ? 0 : x - 1. Tnew never wraps.
- Match(X, r): X.valid && X.tar == r && r != 0. Writes to $0 never create hazards or forwards.
- Stall (combinational):
  - For each D operand r with use u != TUSE_NONE: find the nearest matching stage in priority E > M > W.
  - If that stage's tnew > u, the operand stalls.
  - stall = (rs stalls | rt stalls) & d_valid.
  - Only the nearest match is considered; older matches are shadowed.
- fwd_*_d: nearest matching stage among E, M, W whose tnew == 0 gives the select (E = 1, M = 2, W = 3), else 0. Computed regardless of stall; the value is ignored by the datapath while stalled.
- fwd_*_e: uses E.rs/E.rt against M then W (M has priority). Select = 2 or 3 when the nearest match has tnew == 0, else 0. The Tuse rules guarantee a nonzero-tnew match never reaches here; the bench asserts this.
- stall_cnt increments by 1 at each edge where stall = 1 and reset = 0. It wraps at 2^CNT_W.
- Simultaneous reset and stall: reset wins; the counter is not incremented.
- Reset mid-stall: the next cycle has an empty scoreboard and stall = 0.
- No flush and no delay-slot cancel: the branch delay slot is always executed.
- Latency:
  - stall and fwd_*_d are combinational from the D inputs and the current state.
  - fwd_*_e depends only on registered state.

Decomposition:
- Shared package/macros: TUSE_NONE, fwd select encodings (FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 3), and the scoreboard entry field layout.
- One natural sub-module, hazard_match: given an operand register, its use, and the three entries, returns {stall_req, fwd_sel}. Instantiated four times (D rs/rt, E rs/rt; the E instances receive the E entry masked invalid).

Test Plan:
- addu $3 (tnew 2) then addu rs = $3 use 1 -> stall stays 0. Next cycle fwd_rs_e = 2 (M). One cycle later a third reader sees fwd_rs_d = 3 (W).
- lw $5 (tnew 3) then addu rt = $5 use 1 -> exactly 1 stall cycle, stall_cnt = 1. Then fwd_rt_e = 3 (W).
- lw $5 then beq rs = $5 use 0 -> 2 stall cycles. Then fwd_rs_d = 3 (W), stall_cnt = 2.
- jal (tar 31, tnew 1) then jr $31 use 0 -> no stall. fwd_rs_d = 1 (E) in the cycle jr is in D.
- Writer to $0 (ori $0, tnew 2) then beq rs = $0 -> stall = 0, fwd_rs_d = 0. Also two writers to $7 in E and M -> select follows E only.
- Assert reset during an lw-beq stall -> next cycle stall = 0, all fwd = 0, stall_cnt = 0.
